salu_seq: RTL and testbench



---
 rtl/salu_seq_if.sv | 43 ++++
 rtl/salu_seq.sv | 148 ++++++++++++++
 tb/tb_salu_seq.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/salu_seq_if.sv
// Command, register-load, ALU-side and status signals of the salu_seq stage.
// Latency: none; this is only a signal bundle.
// Backpressure: cmd_valid/cmd_ready handshake; everything else is unqualified.
interface salu_seq_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [AW-1:0]    cmd_dst;
  logic [AW-1:0]    cmd_srca;
  logic [AW-1:0]    cmd_srcb;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] operanda;
  logic [WIDTH-1:0] operandb;
  logic [3:0]       mux;
  logic [WIDTH-1:0] alu_result;
  logic             done;
  logic [WIDTH-1:0] result_out;
  logic             flag_zero;
  logic             flag_neg;
  logic             flag_err;
  logic [15:0]      op_count;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb,
    input  ld_en, ld_addr, ld_data, alu_result,
    output cmd_ready, operanda, operandb, mux,
    output done, result_out, flag_zero, flag_neg, flag_err, op_count
  );

  // Command source / ALU / status consumer side
  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb,
    output ld_en, ld_addr, ld_data, alu_result,
    input  cmd_ready, operanda, operandb, mux,
    input  done, result_out, flag_zero, flag_neg, flag_err, op_count
  );
endinterface

// File: rtl/salu_seq.sv
// Sequencer/writeback around a combinational 8-bit ALU: IDLE -> EXEC -> WB.
// Latency: operands at ALU 1 cycle after accept, done 2 cycles after accept.
// Backpressure: cmd_ready only in IDLE, one command per 3 cycles.
// Optional op_count perf counter enabled by macro SALU_SEQ_PERF_EN.
module salu_seq #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int AW    = 2
) (
  input  logic      clk,
  input  logic      reset,
  salu_seq_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [3:0]       mux_q, mux_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic             rej_q, rej_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             fz_q, fz_d, fn_q, fn_d, fe_q, fe_d;
  logic             reject;

  // Undefined opcodes and divide-by-zero are flagged at accept time
  always_comb begin
    reject = (bus.cmd_op >= 4'hC) ||
             ((bus.cmd_op == 4'h3) && (rf_q[bus.cmd_srcb] == '0));
  end

  // Next-state and datapath; operands always come from pre-write rf values
  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mux_d    = mux_q;
    dst_d    = dst_q;
    rej_d    = rej_q;
    res_d    = res_q;
    done_d   = 1'b0;
    result_d = result_q;
    fz_d     = fz_q;
    fn_d     = fn_q;
    fe_d     = fe_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ld_en) rf_d[bus.ld_addr] = bus.ld_data;
        if (bus.cmd_valid) begin
          opa_d   = rf_q[bus.cmd_srca];
          opb_d   = rf_q[bus.cmd_srcb];
          // A rejected op shows the ALU opcode 0 so it never sees 0xC-0xF
          mux_d   = reject ? 4'h0 : bus.cmd_op;
          dst_d   = bus.cmd_dst;
          rej_d   = reject;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = bus.alu_result;
        done_d  = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (!rej_q) begin
          rf_d[dst_q] = res_q;
          result_d    = res_q;
          fz_d        = (res_q == '0);
          fn_d        = res_q[WIDTH-1];
          fe_d        = 1'b0;
        end else begin
          fe_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight command
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      mux_q    <= '0;
      dst_q    <= '0;
      rej_q    <= 1'b0;
      res_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      fz_q     <= 1'b0;
      fn_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mux_q    <= mux_d;
      dst_q    <= dst_d;
      rej_q    <= rej_d;
      res_q    <= res_d;
      done_q   <= done_d;
      result_q <= result_d;
      fz_q     <= fz_d;
      fn_q     <= fn_d;
      fe_q     <= fe_d;
    end
  end

`ifdef SALU_SEQ_PERF_EN
  logic [15:0] cnt_q, cnt_d;

  // Count every done pulse (rejects included), saturating
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_WB) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.op_count = cnt_q;
`else
  assign bus.op_count = '0;
`endif

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.operanda   = opa_q;
  assign bus.operandb   = opb_q;
  assign bus.mux        = mux_q;
  assign bus.done       = done_q;
  assign bus.result_out = result_q;
  assign bus.flag_zero  = fz_q;
  assign bus.flag_neg   = fn_q;
  assign bus.flag_err   = fe_q;

endmodule

// File: tb/tb_salu_seq.sv
// Bench for salu_seq with a behavioural ALU attached on the ALU-side signals.
// Latency: checks operand (1 cycle) and done (2 cycle) timing after accept.
// Backpressure: checks cmd_ready pattern under back-to-back cmd_valid.
module tb_salu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  salu_seq_if #(.WIDTH(8), .AW(2)) bus ();

  salu_seq #(.WIDTH(8), .NREG(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural 8-bit ALU
  logic [7:0] alu_y;
  always_comb begin
    alu_y = 8'h00;
    case (bus.mux)
      4'h0: alu_y = bus.operanda + bus.operandb;
      4'h1: alu_y = bus.operanda - bus.operandb;
      4'h2: alu_y = bus.operanda * bus.operandb;
      4'h3: alu_y = (bus.operandb == 8'h00) ? 8'hFF : bus.operanda / bus.operandb;
      4'h4: alu_y = ~bus.operanda;
      4'h5: alu_y = bus.operanda & bus.operandb;
      4'h6: alu_y = bus.operanda | bus.operandb;
      4'h7: alu_y = ~(bus.operanda & bus.operandb);
      4'h8: alu_y = ~(bus.operanda | bus.operandb);
      4'h9: alu_y = bus.operanda ^ bus.operandb;
      4'hA: alu_y = {bus.operanda[6:0], 1'b0};
      4'hB: alu_y = {1'b0, bus.operanda[7:1]};
      default: alu_y = 8'hEE;
    endcase
  end
  assign bus.alu_result = alu_y;

  typedef struct {
    logic [3:0] op;
    logic [1:0] dst;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] res;
  } sb_t;

  int         total = 0;
  int         bad   = 0;
  vec_t       vecs [14];
  sb_t        sb_q [$];
  logic [7:0] exp_rf [4];
  logic [7:0] exp_out;
  logic       exp_z, exp_n, exp_e;
  int         exp_cnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] cnt_exp();
`ifdef SALU_SEQ_PERF_EN
    return exp_cnt[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.ld_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;
    exp_out = 8'h00;
    exp_z = 1'b0;
    exp_n = 1'b0;
    exp_e = 1'b0;
    exp_cnt = 0;
    sb_q.delete();
  endtask

  task automatic load(input logic [1:0] addr, input logic [7:0] data);
    bus.ld_en = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    tick();
    bus.ld_en = 1'b0;
    exp_rf[addr] = data;
  endtask

  // One command from IDLE back to IDLE, with optional loads at accept and during EXEC/WB
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [7:0] res, input logic err,
                         input logic acc_ld, input logic [1:0] acc_addr, input logic [7:0] acc_data,
                         input logic late_ld, input logic [1:0] late_addr, input logic [7:0] late_data);
    logic [7:0] ea, eb;
    sb_t e;
    int n;
    ea = exp_rf[sa];
    eb = exp_rf[sb];
    check("ready_idle", bus.cmd_ready, 1);
    e.err = err;
    e.res = res;
    sb_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_dst = dst;
    bus.cmd_srca = sa;
    bus.cmd_srcb = sb;
    bus.ld_en = acc_ld;
    bus.ld_addr = acc_addr;
    bus.ld_data = acc_data;
    if (acc_ld) exp_rf[acc_addr] = acc_data;
    tick();
    bus.cmd_valid = 1'b0;
    bus.ld_en = late_ld;
    bus.ld_addr = late_addr;
    bus.ld_data = late_data;
    check("ready_exec", bus.cmd_ready, 0);
    check("mux_exec", bus.mux, err ? 4'h0 : op);
    check("operanda", bus.operanda, ea);
    check("operandb", bus.operandb, eb);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done !== 1'b1 && n < 4);
    check("done_seen", bus.done, 1);
    if (bus.done !== 1'b1) begin
      void'(sb_q.pop_front());
      bus.ld_en = 1'b0;
      return;
    end
    check("done_latency", n[15:0], 1);
    tick();
    bus.ld_en = 1'b0;
    check("done_pulse", bus.done, 0);
    e = sb_q.pop_front();
    exp_cnt++;
    if (e.err) begin
      exp_e = 1'b1;
    end else begin
      exp_out = e.res;
      exp_rf[dst] = e.res;
      exp_z = (e.res == 8'h00);
      exp_n = e.res[7];
      exp_e = 1'b0;
    end
    check("result_out", bus.result_out, exp_out);
    check("flag_zero", bus.flag_zero, exp_z);
    check("flag_neg", bus.flag_neg, exp_n);
    check("flag_err", bus.flag_err, exp_e);
  endtask

  task automatic cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [7:0] res, input logic err);
    run_cmd(op, dst, sa, sb, res, err, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic readback(input logic [1:0] r);
    cmd(4'h6, r, r, r, exp_rf[r], 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic prev_done;
    sb_t  e;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 4'h0;
    bus.cmd_dst = 2'd0;
    bus.cmd_srca = 2'd0;
    bus.cmd_srcb = 2'd0;
    bus.ld_en = 1'b0;
    bus.ld_addr = 2'd0;
    bus.ld_data = 8'h00;
    reset = 1'b1;

    //          op     dst   a      b      res    err
    vecs[0]  = '{4'h0, 2'd2, 8'h05, 8'h03, 8'h08, 1'b0};
    vecs[1]  = '{4'h0, 2'd3, 8'h80, 8'h80, 8'h00, 1'b0};
    vecs[2]  = '{4'h1, 2'd2, 8'h00, 8'h01, 8'hFF, 1'b0};
    vecs[3]  = '{4'h2, 2'd3, 8'h10, 8'h03, 8'h30, 1'b0};
    vecs[4]  = '{4'h3, 2'd2, 8'h64, 8'h07, 8'h0E, 1'b0};
    vecs[5]  = '{4'h3, 2'd3, 8'h55, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{4'h4, 2'd2, 8'h0F, 8'h33, 8'hF0, 1'b0};
    vecs[7]  = '{4'h9, 2'd3, 8'hAA, 8'hFF, 8'h55, 1'b0};
    vecs[8]  = '{4'hA, 2'd2, 8'h81, 8'h00, 8'h02, 1'b0};
    vecs[9]  = '{4'hB, 2'd3, 8'h81, 8'h00, 8'h40, 1'b0};
    vecs[10] = '{4'hE, 2'd2, 8'h12, 8'h34, 8'h00, 1'b1};
    vecs[11] = '{4'h8, 2'd3, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[12] = '{4'h7, 2'd2, 8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[13] = '{4'h5, 2'd3, 8'hF0, 8'h3C, 8'h30, 1'b0};

    do_reset();
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_opa", bus.operanda, 0);
    check("rst_opb", bus.operandb, 0);
    check("rst_mux", bus.mux, 0);
    check("rst_result", bus.result_out, 0);
    check("rst_flags", {13'd0, bus.flag_zero, bus.flag_neg, bus.flag_err}, 0);
    check("rst_count", bus.op_count, 0);

    // Table: operands in rf0/rf1, then read the destination back
    for (int i = 0; i < 14; i++) begin
      load(2'd0, vecs[i].a);
      load(2'd1, vecs[i].b);
      cmd(vecs[i].op, vecs[i].dst, 2'd0, 2'd1, vecs[i].res, vecs[i].err);
      readback(vecs[i].dst);
    end
    check("count_table", bus.op_count, cnt_exp());

    // Same-cycle load is not seen by the accepted command; loads in EXEC/WB are dropped
    load(2'd0, 8'h11);
    load(2'd1, 8'h0F);
    run_cmd(4'h6, 2'd2, 2'd0, 2'd1, 8'h1F, 1'b0, 1'b1, 2'd0, 8'h22, 1'b1, 2'd1, 8'h77);
    readback(2'd0);
    readback(2'd1);
    readback(2'd2);

    // Back-to-back: cmd_valid held high, one accept every 3 cycles
    load(2'd0, 8'h3C);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 4'h6;
    bus.cmd_dst = 2'd3;
    bus.cmd_srca = 2'd0;
    bus.cmd_srcb = 2'd0;
    prev_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (prev_done) begin
        e = sb_q.pop_front();
        check("b2b_result", bus.result_out, e.res);
      end
      if (i % 3 == 0) begin
        check("b2b_ready_hi", bus.cmd_ready, 1);
        e.err = 1'b0;
        e.res = 8'h3C;
        sb_q.push_back(e);
      end else begin
        check("b2b_ready_lo", bus.cmd_ready, 0);
      end
      check("b2b_done", bus.done, (i % 3 == 2) ? 1'b1 : 1'b0);
      prev_done = bus.done;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("b2b_result", bus.result_out, e.res);
    end
    check("b2b_queue_empty", sb_q.size(), 0);
    exp_rf[3] = 8'h3C;
    exp_out = 8'h3C;
    exp_z = 1'b0;
    exp_n = 1'b0;
    exp_e = 1'b0;
    exp_cnt += 3;
    check("count_b2b", bus.op_count, cnt_exp());

    // Reset while a command is in EXEC
    load(2'd0, 8'h05);
    load(2'd1, 8'h03);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 4'h0;
    bus.cmd_dst = 2'd2;
    bus.cmd_srca = 2'd0;
    bus.cmd_srcb = 2'd1;
    tick();
    bus.cmd_valid = 1'b0;
    check("rx_in_exec", bus.cmd_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rx_ready", bus.cmd_ready, 1);
    check("rx_done", bus.done, 0);
    check("rx_opa", bus.operanda, 0);
    check("rx_mux", bus.mux, 0);
    check("rx_result", bus.result_out, 0);
    check("rx_count", bus.op_count, 0);
    tick();
    check("rx_no_done", bus.done, 0);
    for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;
    exp_out = 8'h00;
    exp_z = 1'b0;
    exp_n = 1'b0;
    exp_e = 1'b0;
    exp_cnt = 0;
    cmd(4'h6, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
    readback(2'd3);

    // Five commands after reset, one rejected
    do_reset();
    load(2'd0, 8'h09);
    load(2'd1, 8'h02);
    cmd(4'h0, 2'd2, 2'd0, 2'd1, 8'h0B, 1'b0);
    cmd(4'h1, 2'd3, 2'd0, 2'd1, 8'h07, 1'b0);
    cmd(4'hF, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1);
    cmd(4'h2, 2'd3, 2'd0, 2'd1, 8'h12, 1'b0);
    cmd(4'h5, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
    check("count_five", bus.op_count, cnt_exp());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
